// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: host-to-device PS/2 command sender (inhibit, request-to-send, 11-bit frame, ACK check).
// Latency: INHIBIT_CYC+2 cycles to clock release, then device-paced 11 falling edges + line release + 1.
// Backpressure: tx_start ignored while busy and in the done cycle; PS2_TX_RETRY_EN enables one automatic resend.
module ps2_host_tx #(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int FILT_LEN    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic       rx_block
);
    localparam int IW = $clog2(INHIBIT_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAITREL, S_DONE, S_FAIL
    } state_t;

    state_t        state;
    logic [1:0]    c_sync, d_sync;
    logic          c_filt, c_filt_d, fe;
    logic [FW-1:0] fcnt;
    logic [9:0]    frame;
    logic [3:0]    bitcnt;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic          in_to_phase, fail_now, retry_ok;

`ifdef PS2_TX_RETRY_EN
    logic retried;
    assign retry_ok = ~retried;
`else
    assign retry_ok = 1'b0;
`endif

    assign rx_block = tx_busy;

    // Two-stage synchronisers; idle bus level is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], ps2c_in};
            d_sync <= {d_sync[0], ps2d_in};
        end
    end

    // Clock glitch filter: a new level is accepted after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_filt   <= 1'b1;
            c_filt_d <= 1'b1;
            fcnt     <= '0;
        end else begin
            c_filt_d <= c_filt;
            if (c_sync[1] == c_filt) begin
                fcnt <= '0;
            end else if (fcnt == FILT_LAST) begin
                c_filt <= c_sync[1];
                fcnt   <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign fe = c_filt_d & ~c_filt;

    // Failure sources: watchdog expiry while the device paces the frame, or no ACK on the 11th edge.
    always_comb begin
        in_to_phase = (state == S_SEND) || (state == S_ACK) || (state == S_WAITREL);
        fail_now    = (in_to_phase && (tcnt == TO_LAST)) ||
                      ((state == S_ACK) && fe && d_sync[1]);
    end

    // Transfer sequencer with registered line enables and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            frame   <= '0;
            bitcnt  <= '0;
            icnt    <= '0;
            tcnt    <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retried <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (fail_now) begin
                if (retry_ok) begin
                    // Resend the same frame from the inhibit phase, silently.
                    ps2c_oe <= 1'b1;
                    ps2d_oe <= 1'b0;
                    icnt    <= '0;
                    bitcnt  <= '0;
                    state   <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retried <= 1'b1;
`endif
                end else begin
                    ps2c_oe <= 1'b0;
                    ps2d_oe <= 1'b0;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    tx_err  <= 1'b1;
                    state   <= S_FAIL;
                end
            end else begin
                if (in_to_phase) tcnt <= tcnt + 1'b1;
                case (state)
                    S_IDLE: begin
                        if (tx_start) begin
                            frame   <= {1'b1, ~^tx_data, tx_data};
                            ps2c_oe <= 1'b1;
                            ps2d_oe <= 1'b0;
                            icnt    <= '0;
                            bitcnt  <= '0;
                            tx_busy <= 1'b1;
                            state   <= S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            retried <= 1'b0;
`endif
                        end
                    end
                    S_INHIBIT: begin
                        if (icnt == INH_LAST) begin
                            ps2d_oe <= 1'b1;
                            state   <= S_RTS;
                        end else begin
                            icnt <= icnt + 1'b1;
                        end
                    end
                    S_RTS: begin
                        ps2c_oe <= 1'b0;
                        tcnt    <= '0;
                        bitcnt  <= '0;
                        state   <= S_SEND;
                    end
                    S_SEND: begin
                        // Stop bit is frame[9]=1, so the 10th edge releases data.
                        if (fe) begin
                            ps2d_oe <= ~frame[bitcnt];
                            bitcnt  <= bitcnt + 1'b1;
                            if (bitcnt == 4'd9) state <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (fe) state <= S_WAITREL;
                    end
                    S_WAITREL: begin
                        if (c_sync[1] && d_sync[1]) begin
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                    S_DONE, S_FAIL: state <= S_IDLE;
                    default:        state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx: randomized and directed frames against a behavioural PS/2 keyboard model.
// Latency: device-paced; every wait on the DUT is bounded by a cycle budget.
// Backpressure: exercises ignored tx_start during a frame and the NACK / timeout failure paths.
module tb_ps2_host_tx;
    localparam int INH = 50;
    localparam int TO  = 3000;
    localparam int FL  = 8;
    localparam int H   = 30;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 2;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_c_low = 1'b0, dev_d_low = 1'b0, dev_glitch = 1'b0;
    logic       c_line, d_line;
    logic       ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err, rx_block;

    int tests = 0, fails = 0;
    int n_done = 0, n_err = 0, n_inh = 0, n_busy_done = 0, n_rxb_bad = 0, n_err_alone = 0;

    always #5 clk = ~clk;

    assign c_line = ~(ps2c_oe | dev_c_low | dev_glitch);
    assign d_line = ~(ps2d_oe | dev_d_low);

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TO), .FILT_LEN(FL)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_start(tx_start),
        .ps2c_in(c_line), .ps2d_in(d_line), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .rx_block(rx_block)
    );

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_done && tx_err) n_err++;
        if (tx_err && !tx_done) n_err_alone++;
        if (tx_done && tx_busy) n_busy_done++;
        if (ps2c_oe && !ps2d_oe) n_inh++;
        if (rx_block !== tx_busy) n_rxb_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Wait for request-to-send: clock released while data held low.
    task automatic wait_rts(output bit ok);
        int w = 0;
        while (!(c_line && !d_line) && w < INH + 200) begin
            @(negedge clk);
            w++;
        end
        ok = (w < INH + 200);
        chk("rts_seen", 32'(ok), 32'd1);
    endtask

    // Keyboard model: clocks 11 falling edges, samples host data at the end of each low phase.
    task automatic dev_frame(input bit nack, input bit glitch, input bit inject, output logic [10:0] bits);
        bit ok;
        bits = '0;
        wait_rts(ok);
        if (!ok) return;
        cyc(40);
        bits[0] = d_line;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_d_low = !nack;
            dev_c_low = 1'b1;
            if (inject && k == 4) begin
                cyc(3);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                cyc(1);
                tx_start = 1'b0;
                cyc(H - 4);
            end else begin
                cyc(H);
            end
            if (k <= 10) bits[k] = d_line;
            dev_c_low = 1'b0;
            if (glitch && k == 5) begin
                cyc(H / 2);
                #4.5 dev_glitch = 1'b1;
                #1   dev_glitch = 1'b0;
                cyc(H / 2);
            end else begin
                cyc(H);
            end
        end
        dev_d_low = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] d, input bit nack, input bit glitch, input bit inject);
        logic [10:0] bits;
        logic [10:0] exp_f;
        logic        par;
        int d0, e0, i0, b0, w, tries;
        d0 = n_done; e0 = n_err; i0 = n_inh; b0 = n_busy_done; w = 0;
        tries = nack ? ATTEMPTS : 1;
        // Odd parity: parity bit set when the byte has an even number of ones.
        par   = (($countones(d) % 2) == 0);
        exp_f = 11'(d) * 11'd2 + 11'(par) * 11'd512 + 11'd1024;
        send_cmd(d);
        for (int a = 0; a < tries; a++) begin
            dev_frame(nack, glitch, inject, bits);
            chk("frame_bits", 32'(bits), 32'(exp_f));
            chk("parity_bit", 32'(bits[9]), 32'(par));
        end
        while (n_done == d0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("done_count", 32'(n_done - d0), 32'd1);
        chk("err_count", 32'(n_err - e0), 32'(nack));
        chk("inhibit_cyc", 32'(n_inh - i0), 32'(INH * tries));
        chk("busy_at_done", 32'(n_busy_done - b0), 32'd0);
        @(negedge clk);
        chk("idle_after", 32'({ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err}), 32'd0);
    endtask

    initial begin
        int d0, e0, cnt, w;
        bit ok;
        #2 reset_n = 1'b0;
        cyc(3);
        chk("reset_outs", 32'({ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err, rx_block}), 32'd0);
        reset_n = 1'b1;
        cyc(5);
        chk("idle_outs", 32'({ps2c_oe, ps2d_oe, tx_busy, tx_done, tx_err, rx_block}), 32'd0);

        // Asynchronous reset in the middle of the inhibit phase.
        d0 = n_done;
        send_cmd(8'h5A);
        cyc(20);
        chk("inhibit_busy", 32'({ps2c_oe, tx_busy}), 32'd3);
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 32'({ps2c_oe, ps2d_oe, tx_busy}), 32'd0);
        cyc(3);
        chk("no_done_on_reset", 32'(n_done - d0), 32'd0);
        reset_n = 1'b1;
        cyc(5);

        // Directed bytes, glitch, ignored start, then random bytes.
        do_frame(8'hED, 1'b0, 1'b0, 1'b0);
        do_frame(8'hF4, 1'b0, 1'b0, 1'b0);
        do_frame(8'h00, 1'b0, 1'b0, 1'b0);
        do_frame(8'hFF, 1'b0, 1'b0, 1'b0);
        do_frame(8'hED, 1'b0, 1'b1, 1'b0);
        do_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) do_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);

        // Device leaves data high on the 11th edge.
        do_frame(8'hA7, 1'b1, 1'b0, 1'b0);

        // Device never clocks: watchdog releases both lines.
        d0 = n_done; e0 = n_err;
        send_cmd(8'hA5);
        for (int a = 0; a < ATTEMPTS; a++) begin
            wait_rts(ok);
            cnt = 0;
            while (ps2d_oe && cnt < TO + 100) begin
                @(negedge clk);
                cnt++;
            end
            chk("timeout_cycles", 32'(cnt), 32'(TO));
        end
        w = 0;
        while (n_done == d0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("timeout_done", 32'(n_done - d0), 32'd1);
        chk("timeout_err", 32'(n_err - e0), 32'd1);
        @(negedge clk);
        chk("timeout_lines", 32'({ps2c_oe, ps2d_oe, tx_busy}), 32'd0);

        chk("rx_block_eq_busy", 32'(n_rxb_bad), 32'd0);
        chk("err_without_done", 32'(n_err_alone), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
